// File: rtl/fifo_pkg.sv
// Shared helpers for burst_fifo: width functions, threshold compares and error-flag bit indices.
package fifo_pkg;

    localparam int ERR_OVERFLOW  = 0;
    localparam int ERR_UNDERFLOW = 1;
    localparam int ERR_BITS      = 2;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int count_width(input int load_words);
        return $clog2(load_words + 1);
    endfunction

    function automatic logic at_or_above(input int unsigned level, input int unsigned threshold);
        return level >= threshold;
    endfunction

    function automatic logic at_or_below(input int unsigned level, input int unsigned threshold);
        return level <= threshold;
    endfunction

endpackage

// File: rtl/burst_fifo_mem.sv
// Storage for burst_fifo: LOAD_WORDS-wide write port with per-word enables and wrapping
// addresses, plus one asynchronous read port.
module burst_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int LOAD_WORDS = 4,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic                             clk,
    input  logic [LOAD_WORDS-1:0]            write_en,
    input  logic [AW-1:0]                    write_base,
    input  logic [LOAD_WORDS*DATA_WIDTH-1:0] write_data,
    input  logic [AW-1:0]                    read_addr,
    output logic [DATA_WIDTH-1:0]            read_data
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    // Word i of a burst lands at base+i; the AW-bit sum wraps at the end of the array.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LOAD_WORDS; i++) begin
            if (write_en[i]) begin
                mem[write_base + AW'(i)] <= write_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/burst_fifo.sv
// Synchronous FIFO with single-word writes, atomic burst loads, fill thresholds and sticky errors.
// Define FIFO_FWFT_EN for first-word fall-through reads; default is a registered read.
module burst_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int LOAD_WORDS = 4,
    parameter int AF_MARGIN  = 2,
    parameter int AE_MARGIN  = 2,
    localparam int AW = addr_width(FIFO_DEPTH),
    localparam int CW = count_width(LOAD_WORDS)
) (
    input  logic                             clkIn,
    input  logic                             resetIn,
    input  logic                             writeEnableIn,
    input  logic [DATA_WIDTH-1:0]            dataIn,
    input  logic                             loadEnableIn,
    input  logic [CW-1:0]                    loadCountIn,
    input  logic [LOAD_WORDS*DATA_WIDTH-1:0] loadIn,
    input  logic                             readEnableIn,
    input  logic                             clearErrIn,
    output logic [DATA_WIDTH-1:0]            serialDataOut,
    output logic                             dataValidOut,
    output logic                             fullOut,
    output logic                             emptyOut,
    output logic                             almostFullOut,
    output logic                             almostEmptyOut,
    output logic                             writeReadyOut,
    output logic                             readReadyOut,
    output logic [AW:0]                      countOut,
    output logic [AW-1:0]                    tailPointerOut,
    output logic                             overflowOut,
    output logic                             underflowOut
);

    localparam int NW = AW + 1;

    logic [AW-1:0]                    head;
    logic [AW-1:0]                    tail;
    logic [NW-1:0]                    count;
    logic [ERR_BITS-1:0]              errors;

    logic [CW-1:0]                    load_words;
    logic [NW-1:0]                    space;
    logic                             read_ok;
    logic                             load_ok;
    logic                             write_ok;
    logic [NW-1:0]                    write_words;
    logic [LOAD_WORDS-1:0]            mem_write_en;
    logic [LOAD_WORDS*DATA_WIDTH-1:0] mem_write_data;
    logic [DATA_WIDTH-1:0]            mem_read_data;
    logic                             overflow_hit;
    logic                             underflow_hit;
    logic                             empty;
    logic                             full;

    assign empty = (count == '0);
    assign full  = (count == NW'(FIFO_DEPTH));

    // Load space is judged on the count at cycle start, so a same-cycle pop never makes room for a burst.
    always_comb begin
        load_words     = (loadCountIn > CW'(LOAD_WORDS)) ? CW'(LOAD_WORDS) : loadCountIn;
        space          = NW'(FIFO_DEPTH) - count;
        read_ok        = readEnableIn && !empty;
        load_ok        = loadEnableIn && (NW'(load_words) <= space);
        write_ok       = !loadEnableIn && writeEnableIn && (!full || read_ok);
        write_words    = '0;
        mem_write_en   = '0;
        mem_write_data = loadIn;
        if (!loadEnableIn) begin
            mem_write_data[DATA_WIDTH-1:0] = dataIn;
        end
        if (load_ok) begin
            write_words = NW'(load_words);
            for (int i = 0; i < LOAD_WORDS; i++) begin
                mem_write_en[i] = (CW'(i) < load_words);
            end
        end else if (write_ok) begin
            write_words     = NW'(1);
            mem_write_en[0] = 1'b1;
        end
        overflow_hit  = (loadEnableIn && !load_ok) || (writeEnableIn && !write_ok);
        underflow_hit = readEnableIn && empty;
    end

    burst_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LOAD_WORDS (LOAD_WORDS)
    ) u_mem (
        .clk        (clkIn),
        .write_en   (mem_write_en),
        .write_base (tail),
        .write_data (mem_write_data),
        .read_addr  (head),
        .read_data  (mem_read_data)
    );

    // A new error wins over a same-cycle clear.
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            errors <= '0;
        end else begin
            head   <= head + AW'(read_ok);
            tail   <= tail + write_words[AW-1:0];
            count  <= count + write_words - NW'(read_ok);
            errors[ERR_OVERFLOW]  <= (errors[ERR_OVERFLOW]  && !clearErrIn) || overflow_hit;
            errors[ERR_UNDERFLOW] <= (errors[ERR_UNDERFLOW] && !clearErrIn) || underflow_hit;
        end
    end

`ifdef FIFO_FWFT_EN
    assign serialDataOut = mem_read_data;
    assign dataValidOut  = !empty;
`else
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            serialDataOut <= '0;
            dataValidOut  <= 1'b0;
        end else begin
            dataValidOut <= read_ok;
            if (read_ok) begin
                serialDataOut <= mem_read_data;
            end
        end
    end
`endif

    assign fullOut        = full;
    assign emptyOut       = empty;
    assign almostFullOut  = at_or_above(32'(count), FIFO_DEPTH - AF_MARGIN);
    assign almostEmptyOut = at_or_below(32'(count), AE_MARGIN);
    assign writeReadyOut  = !full;
    assign readReadyOut   = !empty;
    assign countOut       = count;
    assign tailPointerOut = tail;
    assign overflowOut    = errors[ERR_OVERFLOW];
    assign underflowOut   = errors[ERR_UNDERFLOW];

endmodule

// File: tb/tb_burst_fifo.sv
// Self-checking bench for burst_fifo: directed scenarios followed by random traffic against a queue model.
module tb_burst_fifo;

    localparam int DEPTH = 16;
    localparam int LW    = 4;

    logic        clkIn = 1'b0;
    logic        resetIn;
    logic        writeEnableIn;
    logic [7:0]  dataIn;
    logic        loadEnableIn;
    logic [2:0]  loadCountIn;
    logic [31:0] loadIn;
    logic        readEnableIn;
    logic        clearErrIn;
    logic [7:0]  serialDataOut;
    logic        dataValidOut;
    logic        fullOut;
    logic        emptyOut;
    logic        almostFullOut;
    logic        almostEmptyOut;
    logic        writeReadyOut;
    logic        readReadyOut;
    logic [4:0]  countOut;
    logic [3:0]  tailPointerOut;
    logic        overflowOut;
    logic        underflowOut;

    int testsRun  = 0;
    int failCount = 0;

    logic [7:0] q[$];
    int         mTail;
    bit         mOv;
    bit         mUn;
    logic [7:0] mSerial;
    bit         mValid;

    burst_fifo dut (
        .clkIn          (clkIn),
        .resetIn        (resetIn),
        .writeEnableIn  (writeEnableIn),
        .dataIn         (dataIn),
        .loadEnableIn   (loadEnableIn),
        .loadCountIn    (loadCountIn),
        .loadIn         (loadIn),
        .readEnableIn   (readEnableIn),
        .clearErrIn     (clearErrIn),
        .serialDataOut  (serialDataOut),
        .dataValidOut   (dataValidOut),
        .fullOut        (fullOut),
        .emptyOut       (emptyOut),
        .almostFullOut  (almostFullOut),
        .almostEmptyOut (almostEmptyOut),
        .writeReadyOut  (writeReadyOut),
        .readReadyOut   (readReadyOut),
        .countOut       (countOut),
        .tailPointerOut (tailPointerOut),
        .overflowOut    (overflowOut),
        .underflowOut   (underflowOut)
    );

    always #5 clkIn = ~clkIn;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        q.delete();
        mTail   = 0;
        mOv     = 0;
        mUn     = 0;
        mSerial = '0;
        mValid  = 0;
    endtask

    // Compare every visible output against the queue model's view of the FIFO.
    task automatic compareModel();
        int cnt = q.size();
        checkOutput("count", 32'(countOut), cnt);
        checkOutput("empty", 32'(emptyOut), 32'(cnt == 0));
        checkOutput("full", 32'(fullOut), 32'(cnt == DEPTH));
        checkOutput("almost_full", 32'(almostFullOut), 32'(cnt >= DEPTH - 2));
        checkOutput("almost_empty", 32'(almostEmptyOut), 32'(cnt <= 2));
        checkOutput("write_ready", 32'(writeReadyOut), 32'(cnt != DEPTH));
        checkOutput("read_ready", 32'(readReadyOut), 32'(cnt != 0));
        checkOutput("tail", 32'(tailPointerOut), mTail);
        checkOutput("overflow", 32'(overflowOut), 32'(mOv));
        checkOutput("underflow", 32'(underflowOut), 32'(mUn));
`ifdef FIFO_FWFT_EN
        checkOutput("valid", 32'(dataValidOut), 32'(cnt != 0));
        if (cnt != 0) checkOutput("data", 32'(serialDataOut), 32'(q[0]));
`else
        checkOutput("valid", 32'(dataValidOut), 32'(mValid));
        checkOutput("data", 32'(serialDataOut), 32'(mSerial));
`endif
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model, and check after the next falling edge.
    task automatic applyStimulus(input bit we, input logic [7:0] d, input bit le, input logic [2:0] lc,
                                 input logic [31:0] ld, input bit re, input bit ce);
        int  cnt = q.size();
        int  n   = (int'(lc) > LW) ? LW : int'(lc);
        bit  rd  = re && (cnt > 0);
        bit  lok = le && (n <= DEPTH - cnt);
        bit  wok = !le && we && ((cnt < DEPTH) || rd);
        writeEnableIn = we;
        dataIn        = d;
        loadEnableIn  = le;
        loadCountIn   = lc;
        loadIn        = ld;
        readEnableIn  = re;
        clearErrIn    = ce;
        mOv = (mOv && !ce) || (le && !lok) || (we && !wok);
        mUn = (mUn && !ce) || (re && cnt == 0);
        mValid = rd;
        if (rd) mSerial = q.pop_front();
        if (lok) begin
            for (int k = 0; k < n; k++) q.push_back(ld[k*8 +: 8]);
            mTail = (mTail + n) % DEPTH;
        end else if (wok) begin
            q.push_back(d);
            mTail = (mTail + 1) % DEPTH;
        end
        @(posedge clkIn);
        @(negedge clkIn);
        compareModel();
    endtask

    task automatic writeWord(input logic [7:0] d);
        applyStimulus(1, d, 0, 3'd0, 32'h0, 0, 0);
    endtask

    task automatic readWord();
        applyStimulus(0, 8'h00, 0, 3'd0, 32'h0, 1, 0);
    endtask

    initial begin
        resetIn       = 1'b1;
        writeEnableIn = 1'b0;
        dataIn        = '0;
        loadEnableIn  = 1'b0;
        loadCountIn   = '0;
        loadIn        = '0;
        readEnableIn  = 1'b0;
        clearErrIn    = 1'b0;
        modelReset();
        repeat (2) @(negedge clkIn);
        resetIn = 1'b0;
        checkOutput("rst_count", 32'(countOut), 0);
        checkOutput("rst_empty", 32'(emptyOut), 1);
        checkOutput("rst_almost_empty", 32'(almostEmptyOut), 1);
        checkOutput("rst_write_ready", 32'(writeReadyOut), 1);
        compareModel();

        // Scenario 1: asynchronous reset lands between clock edges with data in flight.
        writeWord(8'h11);
        writeWord(8'h22);
        writeWord(8'h33);
        readWord();
        #2 resetIn = 1'b1;
        #1;
        checkOutput("t1_count", 32'(countOut), 0);
        checkOutput("t1_empty", 32'(emptyOut), 1);
        checkOutput("t1_valid", 32'(dataValidOut), 0);
        checkOutput("t1_tail", 32'(tailPointerOut), 0);
        @(negedge clkIn);
        resetIn = 1'b0;
        modelReset();
        compareModel();

        // Scenario 2: two writes then two reads.
        writeWord(8'hA5);
        writeWord(8'h5A);
`ifdef FIFO_FWFT_EN
        checkOutput("t2_fwft_first", 32'(serialDataOut), 32'h A5);
`endif
        readWord();
`ifndef FIFO_FWFT_EN
        checkOutput("t2_first", 32'(serialDataOut), 32'hA5);
        checkOutput("t2_first_valid", 32'(dataValidOut), 1);
`endif
        readWord();
`ifndef FIFO_FWFT_EN
        checkOutput("t2_second", 32'(serialDataOut), 32'h5A);
`endif
        checkOutput("t2_empty", 32'(emptyOut), 1);
        applyStimulus(0, 8'h00, 0, 3'd0, 32'h0, 0, 0);

        // Scenario 3: burst load across the wrap point.
        for (int i = 0; i < 12; i++) writeWord(8'(i));
        for (int i = 0; i < 12; i++) readWord();
        checkOutput("t3_tail_start", 32'(tailPointerOut), 14);
        applyStimulus(0, 8'h00, 1, 3'd4, 32'h04030201, 0, 0);
        checkOutput("t3_count", 32'(countOut), 4);
        checkOutput("t3_tail_wrap", 32'(tailPointerOut), 2);
        for (int i = 0; i < 4; i++) readWord();

        // Scenario 4: rejected burst, clear, then a burst that exactly fills.
        for (int i = 0; i < 13; i++) writeWord(8'($urandom));
        applyStimulus(0, 8'h00, 1, 3'd4, 32'hDEADBEEF, 0, 0);
        checkOutput("t4_count_held", 32'(countOut), 13);
        checkOutput("t4_overflow", 32'(overflowOut), 1);
        applyStimulus(0, 8'h00, 0, 3'd0, 32'h0, 0, 1);
        checkOutput("t4_cleared", 32'(overflowOut), 0);
        applyStimulus(0, 8'h00, 1, 3'd3, 32'h00C3B2A1, 0, 0);
        checkOutput("t4_full", 32'(fullOut), 1);

        // Scenario 5: read+write while full, drain, then read on empty.
        applyStimulus(1, 8'h77, 0, 3'd0, 32'h0, 1, 0);
        checkOutput("t5_count", 32'(countOut), 16);
        checkOutput("t5_no_overflow", 32'(overflowOut), 0);
        for (int i = 0; i < 16; i++) readWord();
        readWord();
        checkOutput("t5_underflow", 32'(underflowOut), 1);
        applyStimulus(0, 8'h00, 0, 3'd0, 32'h0, 0, 1);

        // Scenario 6: threshold flags while filling from empty to full.
        for (int i = 1; i <= DEPTH; i++) begin
            writeWord(8'(i * 3));
            checkOutput("t6_almost_full", 32'(almostFullOut), 32'(i >= 14));
            checkOutput("t6_almost_empty", 32'(almostEmptyOut), 32'(i <= 2));
        end
        for (int i = 0; i < DEPTH; i++) readWord();

        // Random traffic, including oversized burst counts that must clamp.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(bit'($urandom_range(0, 1)), 8'($urandom),
                          ($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)), $urandom,
                          ($urandom_range(0, 9) < 5), ($urandom_range(0, 9) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
